rf_sequencer: RTL

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_sequencer_pkg.sv | 60 ++++++
 rtl/rf_sequencer_if.sv | 51 +++++
 rtl/rf_sequencer_instr_dec.sv | 31 +++
 rtl/rf_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rf_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_sequencer_pkg
// Description : Shared types and constants for the register-file sequencer:
//               FSM state enum, opcode/op field values, writeback-source
//               encodings and the decode helper that picks the first
//               execution state for an instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_GETA   = 3'd2,
        ST_GETB   = 3'd3,
        ST_ALU    = 3'd4,
        ST_STAT   = 3'd5,
        ST_WR_REG = 3'd6,
        ST_WR_IMM = 3'd7
    } state_t;

    // Opcode field [15:13]
    localparam logic [2:0] c_OPC_MOV = 3'b110;
    localparam logic [2:0] c_OPC_ALU = 3'b101;

    // Op field [12:11] under c_OPC_MOV
    localparam logic [1:0] c_OP_MOV_IMM = 2'b10;
    localparam logic [1:0] c_OP_MOV_REG = 2'b00;

    // Op field [12:11] under c_OPC_ALU
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_CMP = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_MVN = 2'b11;

    // Writeback source select
    localparam logic [1:0] c_VSEL_C      = 2'b00;
    localparam logic [1:0] c_VSEL_SXIMM8 = 2'b10;

    // State entered from DECODE. ST_WAIT doubles as the "undefined
    // instruction" marker: an instruction that decodes straight back to
    // WAIT is illegal.
    function automatic state_t first_step(input logic [2:0] opcode,
                                          input logic [1:0] op);
        state_t nxt;
        nxt = ST_WAIT;
        if (opcode == c_OPC_MOV) begin
            if (op == c_OP_MOV_IMM)      nxt = ST_WR_IMM;
            else if (op == c_OP_MOV_REG) nxt = ST_GETB;
        end else if (opcode == c_OPC_ALU) begin
            // MVN only needs the B operand; the other three read A first.
            if (op == c_OP_MVN) nxt = ST_GETB;
            else                nxt = ST_GETA;
        end
        return nxt;
    endfunction

endpackage : rf_sequencer_pkg
`default_nettype wire

// File: rtl/rf_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_sequencer_if
// Description : Bundle of the sequencer's control-side signals.
//               slave  : view used by the sequencer (drives the controls)
//               master : view used by the instruction source / datapath
// Signals     : s        start strobe
//               in       16-bit instruction
//               w        idle/ready
//               readnum / writenum  register-file indices
//               write    register-file write enable
//               loada / loadb / loadc / loads  datapath load strobes
//               asel / bsel         ALU operand selects
//               vsel     writeback source
//               sximm8   sign-extended imm8
//               shift / aluop       held instruction fields
//               illegal  undefined-instruction pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_sequencer_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [15:0] sximm8;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        illegal;

    modport slave (
        input  s, in,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, sximm8, shift, aluop, illegal
    );

    modport master (
        output s, in,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, sximm8, shift, aluop, illegal
    );
endinterface : rf_sequencer_if
`default_nettype wire

// File: rtl/rf_sequencer_instr_dec.sv
`default_nettype none
// ============================================================================
// Module      : instr_dec
// Description : Purely combinational field splitter for the held
//               instruction, plus sign extension of imm8.
// Ports       : i_instr   16-bit instruction
//               o_opcode  [15:13]     o_op    [12:11]
//               o_rn      [10:8]      o_rd    [7:5]
//               o_shift   [4:3]       o_rm    [2:0]
//               o_sximm8  {8{imm8[7]}, imm8}
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dec (
    input  wire logic [15:0] i_instr,
    output logic      [2:0]  o_opcode,
    output logic      [1:0]  o_op,
    output logic      [2:0]  o_rn,
    output logic      [2:0]  o_rd,
    output logic      [1:0]  o_shift,
    output logic      [2:0]  o_rm,
    output logic      [15:0] o_sximm8
);
    assign o_opcode = i_instr[15:13];
    assign o_op     = i_instr[12:11];
    assign o_rn     = i_instr[10:8];
    assign o_rd     = i_instr[7:5];
    assign o_shift  = i_instr[4:3];
    assign o_rm     = i_instr[2:0];
    assign o_sximm8 = {{8{i_instr[7]}}, i_instr[7:0]};
endmodule : instr_dec
`default_nettype wire

// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rf_sequencer
// Description : Moore-style controller sequencing MOV/ADD/AND/CMP/MVN
//               instructions through register-file reads, ALU and
//               writeback. An instruction is captured only in WAIT when
//               the start strobe is high; every control output decodes
//               from the state and the held instruction alone.
// Ports       : clk      rising-edge clock
//               reset_n  synchronous active-low reset
//               bus      rf_sequencer_if.slave (start, instruction, controls)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_sequencer
    import rf_sequencer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset_n,
    rf_sequencer_if.slave   bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_instr;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_shift;
    logic [2:0]  w_rm;
    logic [15:0] w_sximm8;
    state_t      w_first;

    logic        w_w;
    logic [2:0]  w_readnum;
    logic [2:0]  w_writenum;
    logic        w_write;
    logic        w_loada;
    logic        w_loadb;
    logic        w_loadc;
    logic        w_loads;
    logic        w_asel;
    logic [1:0]  w_vsel;
    logic        w_illegal;

    instr_dec u_instr_dec (
        .i_instr  (r_instr),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_shift  (w_shift),
        .o_rm     (w_rm),
        .o_sximm8 (w_sximm8)
    );

    assign w_first = first_step(w_opcode, w_op);

    // State and instruction register. Capture happens only in WAIT so that
    // a held start strobe or a changing instruction bus cannot disturb an
    // operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_WAIT;
            r_instr <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_WAIT && bus.s) begin
                r_instr <= bus.in;
            end
        end
    end

    always_comb begin
        w_next_state = ST_WAIT;
        case (r_state)
            ST_WAIT:   w_next_state = bus.s ? ST_DECODE : ST_WAIT;
            ST_DECODE: w_next_state = w_first;
            ST_GETA:   w_next_state = ST_GETB;
            // CMP stops at the status update instead of producing C.
            ST_GETB:   w_next_state = (w_opcode == c_OPC_ALU && w_op == c_OP_CMP)
                                      ? ST_STAT : ST_ALU;
            ST_ALU:    w_next_state = ST_WR_REG;
            ST_STAT:   w_next_state = ST_WAIT;
            ST_WR_REG: w_next_state = ST_WAIT;
            ST_WR_IMM: w_next_state = ST_WAIT;
            default:   w_next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        w_w        = 1'b0;
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_write    = 1'b0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_asel     = 1'b0;
        w_vsel     = c_VSEL_C;
        w_illegal  = 1'b0;
        case (r_state)
            ST_WAIT:   w_w = 1'b1;
            ST_DECODE: w_illegal = (w_first == ST_WAIT);
            ST_GETA: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            ST_GETB: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
            end
            ST_ALU: begin
                w_loadc = 1'b1;
                // Single-operand instructions (MOV reg, MVN) zero the A side.
                w_asel  = (w_opcode == c_OPC_MOV) ||
                          (w_opcode == c_OPC_ALU && w_op == c_OP_MVN);
            end
            ST_STAT:   w_loads = 1'b1;
            ST_WR_REG: begin
                w_writenum = w_rd;
                w_write    = 1'b1;
                w_vsel     = c_VSEL_C;
            end
            ST_WR_IMM: begin
                w_writenum = w_rn;
                w_write    = 1'b1;
                w_vsel     = c_VSEL_SXIMM8;
            end
            default: ;
        endcase
    end

    assign bus.w        = w_w;
    assign bus.readnum  = w_readnum;
    assign bus.writenum = w_writenum;
    assign bus.write    = w_write;
    assign bus.loada    = w_loada;
    assign bus.loadb    = w_loadb;
    assign bus.loadc    = w_loadc;
    assign bus.loads    = w_loads;
    assign bus.asel     = w_asel;
    assign bus.bsel     = 1'b0;
    assign bus.vsel     = w_vsel;
    assign bus.sximm8   = w_sximm8;
    assign bus.shift    = w_shift;
    assign bus.aluop    = w_op;
    assign bus.illegal  = w_illegal;

endmodule : rf_sequencer
`default_nettype wire
